bcd_scan_display: RTL and testbench

- Downstream consumer of the team's cascaded BCD counters.
- Takes four BCD digits (digit 0 = least significant) and drives one time-multiplexed 4-digit common-anode seven-segment display.
- Latches a coherent snapshot of the digits once per frame, decodes each digit to segments with leading-zero blanking, and inserts a short anode-off gap at every digit change to suppress ghosting.

---
 rtl/bcd_scan_display.sv | 101 ++++++++++
 tb/tb_bcd_scan_display.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Scans four snapshotted BCD digits onto a multiplexed common-anode 7-segment display.
// Each digit slot opens with a short all-dark gap; leading zeros can be blanked.
module bcd_scan_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST_P  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYC);

  logic [PW-1:0] p;
  logic [1:0]    idx;
  logic          load;
  logic [15:0]   snap;
  logic [3:0]    snap_dp;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    cur;
  logic          upper_zero;
  logic [6:0]    cur_seg;

  assign slot_end  = (p == LAST_P);
  assign frame_end = slot_end && (idx == 2'd3);
  assign cur       = snap[{idx, 2'b00} +: 4];

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    upper_zero = 1'b0;
    case (idx)
      2'd3:    upper_zero = (snap[15:12] == 4'd0);
      2'd2:    upper_zero = (snap[15:8]  == 8'd0);
      2'd1:    upper_zero = (snap[15:4]  == 12'd0);
      default: upper_zero = 1'b0;
    endcase
  end

  always_comb begin
    cur_seg = 7'h3F;
    case (cur)
      4'd0: cur_seg = 7'h40;
      4'd1: cur_seg = 7'h79;
      4'd2: cur_seg = 7'h24;
      4'd3: cur_seg = 7'h30;
      4'd4: cur_seg = 7'h19;
      4'd5: cur_seg = 7'h12;
      4'd6: cur_seg = 7'h02;
      4'd7: cur_seg = 7'h78;
      4'd8: cur_seg = 7'h00;
      4'd9: cur_seg = 7'h10;
      default: cur_seg = 7'h3F;
    endcase
    if (lz_en && upper_zero)
      cur_seg = 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p          <= '0;
      idx        <= 2'd0;
      load       <= 1'b1;
      snap       <= 16'h0000;
      snap_dp    <= 4'h0;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      seg_dp     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      p    <= slot_end ? '0 : p + 1'b1;
      idx  <= slot_end ? idx + 2'd1 : idx;
      load <= 1'b0;
      if (load || frame_end) begin
        snap    <= digits;
        snap_dp <= dp;
      end
      frame_tick <= frame_end;
      // Outputs lag (p, idx, snap) by one cycle; the gap darkens every anode.
      if (p < BLANK_P) begin
        an     <= 4'b1111;
        seg    <= 7'h7F;
        seg_dp <= 1'b1;
      end else begin
        an     <= ~(4'b0001 << idx);
        seg    <= cur_seg;
        seg_dp <= ~snap_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed bench for bcd_scan_display against a cycle-count-based reference model.
module tb_bcd_scan_display;

  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  int          n_edges;
  logic [15:0] m_snap;
  logic [3:0]  m_dp;
  logic [6:0]  seg_rom [16];

  bcd_scan_display #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .lz_en(lz_en),
    .an(an), .seg(seg), .seg_dp(seg_dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", tag, n_edges, got, exp);
    end
  endtask

  // Model works from the number of edges since reset: slot = n/DIV, phase = n%DIV.
  task automatic clockEdge();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_tick;
    int          phase;
    int          digit;
    int          value;
    int          upper;
    @(posedge clk);
    e_an   = 4'b1111;
    e_seg  = 7'h7F;
    e_dp   = 1'b1;
    e_tick = 1'b0;
    if (rst) begin
      n_edges = 0;
      m_snap  = 16'h0000;
      m_dp    = 4'h0;
    end else begin
      phase = n_edges % DIV;
      digit = (n_edges / DIV) % 4;
      if (phase >= BLANK) begin
        value = (int'(m_snap) >> (4 * digit)) % 16;
        upper = int'(m_snap) >> (4 * digit);
        e_an  = 4'b1111 & ~(4'b0001 << digit);
        e_seg = (lz_en && digit != 0 && upper == 0) ? 7'h7F : seg_rom[value];
        e_dp  = ~m_dp[digit];
      end
      e_tick = ((n_edges % (4 * DIV)) == (4 * DIV - 1));
      if (n_edges == 0 || e_tick) begin
        m_snap = digits;
        m_dp   = dp;
      end
      n_edges++;
    end
    #1;
    checkOutput("an",         16'(an),         16'(e_an));
    checkOutput("seg",        16'(seg),        16'(e_seg));
    checkOutput("seg_dp",     16'(seg_dp),     16'(e_dp));
    checkOutput("frame_tick", 16'(frame_tick), 16'(e_tick));
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] d, input logic [3:0] p,
                               input logic lz, input int cycles);
    rst    = r;
    digits = d;
    dp     = p;
    lz_en  = lz;
    repeat (cycles) clockEdge();
  endtask

  function automatic logic [15:0] randDigits();
    logic [15:0] v;
    v = 16'h0000;
    for (int k = 0; k < 4; k++)
      if ($urandom_range(0, 2) != 0) v[4*k +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    seg_rom = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    n_edges = 0;
    m_snap  = 16'h0000;
    m_dp    = 4'h0;

    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 2);
    applyStimulus(1'b0, 16'h1234, 4'h0, 1'b0, 8);
    applyStimulus(1'b0, 16'h5678, 4'h0, 1'b0, 40);
    applyStimulus(1'b0, 16'h0050, 4'b1000, 1'b1, 36);
    applyStimulus(1'b0, 16'h0050, 4'b1000, 1'b0, 20);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1, 32);
    applyStimulus(1'b0, 16'h0A00, 4'h0, 1'b1, 32);
    // Land a one-cycle reset inside digit 2 of the current frame.
    while (((n_edges / DIV) % 4) != 2) applyStimulus(1'b0, 16'h0A00, 4'h0, 1'b1, 1);
    applyStimulus(1'b0, 16'h0A00, 4'h0, 1'b1, 1);
    applyStimulus(1'b1, 16'h9087, 4'h5, 1'b0, 1);
    applyStimulus(1'b0, 16'h9087, 4'h5, 1'b0, 20);
    applyStimulus(1'b1, 16'h4321, 4'hF, 1'b1, 10);
    applyStimulus(1'b0, 16'h4321, 4'hF, 1'b1, 20);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0)
        applyStimulus(1'b1, randDigits(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 3));
      else
        applyStimulus(1'b0, randDigits(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 12));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
